// File: rtl/rtc_bus_reader.sv
// rtc_bus_reader: sweeps the 11 RTC time/timer registers over a multiplexed
// address/data bus into a shadow buffer. It publishes the buffer to
// datos0..datos10 in one step on the frame tick.
// Optional feature macro: BCD_CHECK_EN. When it is defined, any byte with a
// nibble above 9 is rejected, and the sticky bcd_err output is added.
module rtc_bus_reader #(
    parameter int unsigned T_PULSE = 4,
    parameter int unsigned T_GAP   = 2,
    parameter logic [7:0]  A_CLK   = 8'h21,
    parameter logic [7:0]  A_TMR   = 8'h41
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic       busy,
    output logic       snap_ready,
    output logic [7:0] datos0,
    output logic [7:0] datos1,
    output logic [7:0] datos2,
    output logic [7:0] datos3,
    output logic [7:0] datos4,
    output logic [7:0] datos5,
    output logic [7:0] datos6,
    output logic [7:0] datos7,
    output logic [7:0] datos8,
    output logic [7:0] datos9,
    output logic [7:0] datos10
`ifdef BCD_CHECK_EN
    ,
    output logic       bcd_err
`endif
);

    localparam int unsigned T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
    localparam int unsigned CW    = $clog2(T_MAX + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(T_GAP - 1);
    localparam logic [3:0]    IDX_LAST   = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP_A,
        S_DATA,
        S_GAP_D
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [3:0]      idx, idx_nxt;

    logic [7:0]      shadow  [0:10];
    logic [7:0]      datos_q [0:10];

    logic            cs_n_nxt, rd_n_nxt, wr_n_nxt, a_d_nxt, ad_oe_nxt;
    logic [7:0]      ad_out_nxt;

    logic            last_pulse, last_gap;
    logic            sweep_go, sweep_end, sample, publish;
    logic [7:0]      sample_val;

    // The first 8 bytes come from the clock bank. The last 3 bytes come from the timer bank.
    function automatic logic [7:0] addr_of(input logic [3:0] i);
        if (i < 4'd8)
            return A_CLK + {4'd0, i};
        else
            return A_TMR + {4'd0, i - 4'd8};
    endfunction

    assign last_pulse = (cnt == PULSE_LAST);
    assign last_gap   = (cnt == GAP_LAST);
    assign sweep_go   = (state == S_IDLE) && start;
    assign sweep_end  = (state == S_GAP_D) && last_gap && (idx == IDX_LAST);
    assign sample     = (state == S_DATA) && last_pulse;
    assign publish    = frame_tick && snap_ready;

`ifdef BCD_CHECK_EN
    logic bad_bcd;
    assign bad_bcd    = (ad_in[7:4] > 4'd9) || (ad_in[3:0] > 4'd9);
    assign sample_val = bad_bcd ? datos_q[idx] : ad_in;
`else
    assign sample_val = ad_in;
`endif

    // State register, phase counter and byte index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic. Each phase lasts until its counter reaches the phase length.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ADDR;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            end
            S_ADDR: begin
                if (last_pulse) begin
                    state_nxt = S_GAP_A;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_GAP_A: begin
                if (last_gap) begin
                    state_nxt = S_DATA;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (last_pulse) begin
                    state_nxt = S_GAP_D;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_GAP_D: begin
                if (last_gap) begin
                    cnt_nxt = '0;
                    if (idx == IDX_LAST) begin
                        state_nxt = S_IDLE;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = S_ADDR;
                        idx_nxt   = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Decode the bus strobes from the next state, so that the strobe registers
    // change on the same edge as the state register.
    always_comb begin
        cs_n_nxt   = 1'b1;
        rd_n_nxt   = 1'b1;
        wr_n_nxt   = 1'b1;
        a_d_nxt    = 1'b1;
        ad_oe_nxt  = 1'b0;
        ad_out_nxt = ad_out;
        case (state_nxt)
            S_ADDR: begin
                cs_n_nxt   = 1'b0;
                wr_n_nxt   = 1'b0;
                a_d_nxt    = 1'b0;
                ad_oe_nxt  = 1'b1;
                ad_out_nxt = addr_of(idx_nxt);
            end
            S_DATA: begin
                cs_n_nxt = 1'b0;
                rd_n_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered bus strobes and the busy flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_n   <= 1'b1;
            rd_n   <= 1'b1;
            wr_n   <= 1'b1;
            a_d    <= 1'b1;
            ad_oe  <= 1'b0;
            ad_out <= '0;
            busy   <= 1'b0;
        end else begin
            cs_n   <= cs_n_nxt;
            rd_n   <= rd_n_nxt;
            wr_n   <= wr_n_nxt;
            a_d    <= a_d_nxt;
            ad_oe  <= ad_oe_nxt;
            ad_out <= ad_out_nxt;
            busy   <= (state_nxt != S_IDLE);
        end
    end

    // Sample ad_in into the shadow buffer on the last cycle of each data phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 11; i++)
                shadow[i] <= '0;
        end else if (sample) begin
            shadow[idx] <= sample_val;
        end
    end

    // The snapshot handshake. The tick uses the registered snap_ready, so a tick
    // on the same edge that completes a sweep waits for the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            snap_ready <= 1'b0;
        else if (sweep_end)
            snap_ready <= 1'b1;
        else if (sweep_go || publish)
            snap_ready <= 1'b0;
    end

    // Copy the whole shadow buffer to the display bytes in one step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 11; i++)
                datos_q[i] <= '0;
        end else if (publish) begin
            for (int unsigned i = 0; i < 11; i++)
                datos_q[i] <= shadow[i];
        end
    end

`ifdef BCD_CHECK_EN
    // Sticky flag for a rejected non-BCD byte. A new sweep clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bcd_err <= 1'b0;
        else if (sweep_go)
            bcd_err <= 1'b0;
        else if (sample && bad_bcd)
            bcd_err <= 1'b1;
    end
`endif

    assign datos0  = datos_q[0];
    assign datos1  = datos_q[1];
    assign datos2  = datos_q[2];
    assign datos3  = datos_q[3];
    assign datos4  = datos_q[4];
    assign datos5  = datos_q[5];
    assign datos6  = datos_q[6];
    assign datos7  = datos_q[7];
    assign datos8  = datos_q[8];
    assign datos9  = datos_q[9];
    assign datos10 = datos_q[10];

endmodule

// File: tb/tb_rtc_bus_reader.sv
// tb_rtc_bus_reader: directed bench for rtc_bus_reader with an RTC bus model,
// an address scoreboard and a publish scoreboard. Define BCD_CHECK_EN to
// exercise the rejection of non-BCD bytes.
module tb_rtc_bus_reader;

    localparam int unsigned T_PULSE = 4;
    localparam int unsigned T_GAP   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] ad_in, ad_out;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy, snap_ready;
    logic [7:0] datos0, datos1, datos2, datos3, datos4, datos5;
    logic [7:0] datos6, datos7, datos8, datos9, datos10;
    logic [87:0] datos_all;
`ifdef BCD_CHECK_EN
    logic       bcd_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [256];
    logic [7:0]  rtc_addr = 8'h00;
    logic [7:0]  addr_tab [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                   8'h27, 8'h28, 8'h41, 8'h42, 8'h43};
    logic [7:0]  addr_q [$];
    logic [87:0] pub_q [$];
    logic [87:0] last_pub = '0;
    int          reads = 0;
    int          wr_len = 0;
    int          rd_len = 0;
    logic        prev_wr = 1'b1;
    logic        prev_rd = 1'b1;
    int          ncyc;

    rtc_bus_reader #(
        .T_PULSE (T_PULSE),
        .T_GAP   (T_GAP),
        .A_CLK   (8'h21),
        .A_TMR   (8'h41)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .ad_in      (ad_in),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .a_d        (a_d),
        .busy       (busy),
        .snap_ready (snap_ready),
        .datos0     (datos0),
        .datos1     (datos1),
        .datos2     (datos2),
        .datos3     (datos3),
        .datos4     (datos4),
        .datos5     (datos5),
        .datos6     (datos6),
        .datos7     (datos7),
        .datos8     (datos8),
        .datos9     (datos9),
        .datos10    (datos10)
`ifdef BCD_CHECK_EN
        ,
        .bcd_err    (bcd_err)
`endif
    );

    assign datos_all = {datos10, datos9, datos8, datos7, datos6, datos5,
                        datos4, datos3, datos2, datos1, datos0};

    always #5 clk = ~clk;

    // RTC model: latch the address during the write strobe, then return the register contents
    always @(posedge clk) if (!cs_n && !wr_n) rtc_addr <= ad_out;
    assign ad_in = mem[rtc_addr];

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: address scoreboard, strobe widths and protocol rules
    always @(negedge clk) begin
        if (!reset) begin
            wr_len  = 0;
            rd_len  = 0;
            prev_wr = 1'b1;
            prev_rd = 1'b1;
        end else begin
            chk("rd_wr_overlap", {87'd0, (!wr_n && !rd_n)}, 88'd0);
            chk("oe_during_read", {87'd0, (!rd_n && ad_oe)}, 88'd0);
            if (!wr_n && prev_wr) begin
                chk("addr_phase_ad_oe_a_d", {86'd0, ad_oe, a_d}, 88'd2);
                if (addr_q.size() == 0)
                    chk("addr_unexpected", {80'd0, ad_out}, 88'hFFFF);
                else
                    chk("addr_value", {80'd0, ad_out}, {80'd0, addr_q.pop_front()});
            end
            if (!rd_n && prev_rd) reads++;
            if (!wr_n) wr_len++;
            else if (!prev_wr) begin
                chk("wr_n_width", wr_len, T_PULSE);
                wr_len = 0;
            end
            if (!rd_n) rd_len++;
            else if (!prev_rd) begin
                chk("rd_n_width", rd_len, T_PULSE);
                rd_len = 0;
            end
            prev_wr = wr_n;
            prev_rd = rd_n;
        end
    end

    // Expected shadow contents, built independently from the RTC model memory
    function automatic logic [87:0] build_exp();
        logic [87:0] r;
        logic [7:0]  v;
        r = '0;
        for (int i = 0; i < 11; i++) begin
            v = mem[addr_tab[i]];
`ifdef BCD_CHECK_EN
            if (v[7:4] > 4'd9 || v[3:0] > 4'd9) v = last_pub[8*i +: 8];
`endif
            r[8*i +: 8] = v;
        end
        return r;
    endfunction

    task automatic start_sweep(input bit push_pub);
        if (push_pub) pub_q.push_back(build_exp());
        for (int i = 0; i < 11; i++) addr_q.push_back(addr_tab[i]);
        reads = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_after_start", {87'd0, busy}, 88'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_done_timeout", {87'd0, busy}, 88'd0);
    endtask

    task automatic tick(input bit expect_pub);
        @(negedge clk);
        chk("snap_ready_before_tick", {87'd0, snap_ready}, {87'd0, expect_pub});
        frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        chk("snap_ready_after_tick", {87'd0, snap_ready}, 88'd0);
        if (expect_pub) begin
            if (pub_q.size() == 0)
                chk("publish_queue_empty", 88'd0, 88'd1);
            else
                last_pub = pub_q.pop_front();
        end
        chk("datos_after_tick", datos_all, last_pub);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h21] = 8'h59; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12;
        mem[8'h24] = 8'h25; mem[8'h25] = 8'h11; mem[8'h26] = 8'h24;
        mem[8'h27] = 8'h03; mem[8'h28] = 8'h47; mem[8'h41] = 8'h45;
        mem[8'h42] = 8'h07; mem[8'h43] = 8'h23;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_strobes", {84'd0, cs_n, rd_n, wr_n, a_d}, 88'hF);
        chk("reset_oe_busy_snap", {85'd0, ad_oe, busy, snap_ready}, 88'd0);
        chk("reset_ad_out", {80'd0, ad_out}, 88'd0);
        chk("reset_datos", datos_all, 88'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Sweep 1: timing, addresses, then publish 50 cycles later
        start_sweep(1'b1);
        wait_done(ncyc);
        chk("sweep1_cycles", ncyc, 132);
        chk("sweep1_snap_ready", {87'd0, snap_ready}, 88'd1);
        chk("sweep1_reads", reads, 11);
        chk("sweep1_addr_q_empty", addr_q.size(), 0);
        chk("sweep1_datos_unpublished", datos_all, 88'd0);
        repeat (50) @(negedge clk);
        tick(1'b1);
        chk("datos0_value", {80'd0, datos0}, 88'h59);
        chk("datos10_value", {80'd0, datos10}, 88'h23);

        // Sweep 2: a tick during the sweep is ignored, and the tick after the sweep publishes
        mem[8'h21] = 8'h58;
        start_sweep(1'b1);
        repeat (60) @(negedge clk);
        tick(1'b0);
        wait_done(ncyc);
        tick(1'b1);
        chk("sweep2_datos0", {80'd0, datos0}, 88'h58);

        // Sweep 3: start pulses during the sweep do not add reads
        start_sweep(1'b0);
        repeat (3) @(negedge clk);
        pulse_start();
        repeat (33) @(negedge clk);
        pulse_start();
        wait_done(ncyc);
        chk("sweep3_reads", reads, 11);
        chk("sweep3_addr_q_empty", addr_q.size(), 0);
        chk("sweep3_snap_ready", {87'd0, snap_ready}, 88'd1);

        // Sweep 4: a start while the snapshot is pending clears it. Reset during a data phase.
        start_sweep(1'b0);
        chk("start_clears_snap", {87'd0, snap_ready}, 88'd0);
        chk("start_keeps_datos", datos_all, last_pub);
        repeat (67) @(negedge clk);
        chk("in_data_phase", {87'd0, rd_n}, 88'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_cs_rd", {86'd0, cs_n, rd_n}, 88'd3);
        chk("async_reset_busy", {87'd0, busy}, 88'd0);
        chk("async_reset_datos", datos_all, 88'd0);
        addr_q.delete();
        last_pub = '0;
        @(negedge clk);
        @(negedge clk) reset = 1'b1;

        // Sweep 5: a clean sweep after reset
        mem[8'h22] = 8'h37;
        start_sweep(1'b1);
        wait_done(ncyc);
        chk("sweep5_cycles", ncyc, 132);
        tick(1'b1);
        chk("sweep5_datos1", {80'd0, datos1}, 88'h37);

        // Sweep 6: the RTC model returns a minutes byte that is not BCD
        mem[8'h22] = 8'h5A;
        start_sweep(1'b1);
        wait_done(ncyc);
        tick(1'b1);
`ifdef BCD_CHECK_EN
        chk("bcd_keep_datos1", {80'd0, datos1}, 88'h37);
        chk("bcd_err_set", {87'd0, bcd_err}, 88'd1);
        start_sweep(1'b0);
        chk("bcd_err_cleared_by_start", {87'd0, bcd_err}, 88'd0);
        wait_done(ncyc);
`else
        chk("unchecked_datos1", {80'd0, datos1}, 88'h5A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
